vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter H_POL, default 0, asserted level of h_sync.
REQ-010 SHALL have parameter V_POL, default 0, asserted level of v_sync.
REQ-011 SHALL have parameter CW, default 11, width of coordinate outputs.
REQ-012 SHALL have parameter FCW, default 16, width of frame_count.
REQ-013 clk_in  input  1  pixel clock; all logic on its rising edge; one clock only.
REQ-014 reset  input  1  synchronous, active-high reset.
REQ-015 run  input  1  level request to generate frames.
REQ-016 h_sync  output  1  horizontal sync, level per H_POL.
REQ-017 v_sync  output  1  vertical sync, level per V_POL.
REQ-018 display_en  output  1  high during visible pixels.
REQ-019 h_count  output  CW  current pixel column.
REQ-020 v_count  output  CW  current line.
REQ-021 line_start  output  1  one-cycle pulse at h_count==0 of every line.
REQ-022 frame_start  output  1  one-cycle pulse at h_count==0, v_count==0.
REQ-023 frame_count  output  FCW  completed frames, wraps modulo 2^FCW.
REQ-024 busy  output  1  high when state is not IDLE.

Function
REQ-025 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both SHALL be less than 2^CW (elaboration-time check).
REQ-026 Internal h counter SHALL count 0..H_TOTAL-1 and wrap to 0; v counter SHALL increment only on h wrap, counting 0..V_TOTAL-1, wrapping to 0.
REQ-027 All outputs SHALL be registered and mutually aligned: outputs in cycle n+1 reflect counter values of cycle n.
REQ-028 display_en SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-029 h_sync SHALL equal H_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL; v_sync same rule on v with V_* and V_POL.
REQ-030 FSM states IDLE, RUN, DRAIN.
REQ-031 IDLE: counters held at 0; display_en, line_start, frame_start 0; syncs at inactive level; run=1 -> RUN next cycle, counting starts from (0,0).
REQ-032 RUN: counters advance every cycle; run=0 -> DRAIN.
REQ-033 DRAIN: counters advance; run=1 -> RUN with no counter disturbance; at h=H_TOTAL-1, v=V_TOTAL-1 -> IDLE, counters to 0.
REQ-034 frame_count SHALL increment once per counter transition from (H_TOTAL-1,V_TOTAL-1), including the one ending DRAIN.
REQ-035 No partial frame SHALL ever be emitted; dropping run mid-frame SHALL complete that frame.

Reset
REQ-036 reset SHALL override run and all state on the same edge: state IDLE, counters 0, frame_count 0, busy 0, display_en 0, pulses 0, h_sync=~H_POL, v_sync=~V_POL, h_count=v_count=0.
REQ-037 reset asserted mid-frame SHALL abort the frame immediately without a frame_count increment.

Structure
REQ-038 Package vga_timing_pkg SHALL hold default 640x480 timing constants and the FSM state encoding.
REQ-039 Sub-module vga_axis_counter (parametrised modulus, enable in, wrap out) SHALL be instantiated twice, for h and v.

Verification
REQ-040 Reset, run=1 held: first frame_start 2 cycles after run rises; line_start period 800 cycles; frame_start period 420000 cycles.
REQ-041 Defaults: h_sync low for exactly 96 cycles starting at h_count=656; v_sync low for lines 490-491; display_en high 640 cycles per line on lines 0-479 only.
REQ-042 Drop run at v_count=100: frame completes to (799,524), busy falls, frame_count +1, outputs idle thereafter.
REQ-043 Drop run then re-raise during DRAIN: counters continue uninterrupted, no extra frame_start, busy stays 1.
REQ-044 Assert reset at (300,200): next cycle all outputs at reset values, frame_count unchanged from pre-frame value 0.
REQ-045 Small params (H 4/1/2/1, V 3/1/1/1, H_POL=1): exhaustive per-cycle compare against reference model over 3 frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the frame-generator state encoding.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MODULUS position counter; wrap flags the enabled step out of the last count.
module vga_axis_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned CW      = 11
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator: run-gated frame sequencer over h/v axis counters,
// with all outputs registered one cycle behind the counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CW       = 11,
  parameter int unsigned FCW      = 16
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           run,
  output logic           h_sync,
  output logic           v_sync,
  output logic           display_en,
  output logic [CW-1:0]  h_count,
  output logic [CW-1:0]  v_count,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count,
  output logic           busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL >= 2**CW) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= 2**CW) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  vga_state_t    state;
  vga_state_t    state_nxt;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          h_wrap;
  logic          frame_end;
  logic          active;

  assign active = (state != ST_IDLE);

  vga_axis_counter #(.MODULUS(H_TOTAL), .CW(CW)) u_h_counter (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (!active),
    .en     (active),
    .count  (h),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(.MODULUS(V_TOTAL), .CW(CW)) u_v_counter (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (!active),
    .en     (h_wrap),
    .count  (v),
    .wrap   (frame_end)
  );

  // Dropping run on the last pixel of a frame goes straight to IDLE so no
  // unrequested extra frame is drained.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (run) state_nxt = ST_RUN;
      ST_RUN:   if (!run) state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (run)            state_nxt = ST_RUN;
        else if (frame_end) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      display_en  <= 1'b0;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      h_count     <= h;
      v_count     <= v;
      display_en  <= active && (h < H_ACT_END) && (v < V_ACT_END);
      h_sync      <= (active && (h >= H_SYNC_BEG) && (h < H_SYNC_END)) ? H_POL : ~H_POL;
      v_sync      <= (active && (v >= V_SYNC_BEG) && (v < V_SYNC_END)) ? V_POL : ~V_POL;
      line_start  <= active && (h == '0);
      frame_start <= active && (h == '0) && (v == '0);
      if (frame_end) begin
        frame_count <= frame_count + FCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing line checks plus a small-parameter instance
// compared cycle by cycle against a behavioural frame model.
module tb_vga_timing_gen;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Default 640x480 instance
  logic        d_reset, d_run;
  logic        d_hs, d_vs, d_de, d_ls, d_fs, d_busy;
  logic [10:0] d_hc, d_vc;
  logic [15:0] d_fc;

  vga_timing_gen u_dut_def (
    .clk_in      (clk_in),
    .reset       (d_reset),
    .run         (d_run),
    .h_sync      (d_hs),
    .v_sync      (d_vs),
    .display_en  (d_de),
    .h_count     (d_hc),
    .v_count     (d_vc),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc),
    .busy        (d_busy)
  );

  // Small instance: 8 x 6 total, 4 x 3 visible, positive h_sync
  localparam int SHA = 4, SHFP = 1, SHS = 2, SHBP = 1;
  localparam int SVA = 3, SVFP = 1, SVS = 1, SVBP = 1;
  localparam int SHT = SHA + SHFP + SHS + SHBP;
  localparam int SVT = SVA + SVFP + SVS + SVBP;

  logic        s_reset, s_run;
  logic        s_hs, s_vs, s_de, s_ls, s_fs, s_busy;
  logic [10:0] s_hc, s_vc;
  logic [15:0] s_fc;

  vga_timing_gen #(
    .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
    .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP),
    .H_POL    (1'b1)
  ) u_dut_sml (
    .clk_in      (clk_in),
    .reset       (s_reset),
    .run         (s_run),
    .h_sync      (s_hs),
    .v_sync      (s_vs),
    .display_en  (s_de),
    .h_count     (s_hc),
    .v_count     (s_vc),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc),
    .busy        (s_busy)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model of the small instance
  int ms, mh, mv, mfc;
  int e_hc, e_vc, e_de, e_hs, e_vs, e_ls, e_fs, e_busy, e_fc;
  bit mdl_valid = 1'b0;

  task automatic model_step(input bit rst, input bit rn);
    bit act, last;
    if (rst) begin
      ms = 0; mh = 0; mv = 0; mfc = 0;
      e_hc = 0; e_vc = 0; e_de = 0; e_ls = 0; e_fs = 0;
      e_hs = 0; e_vs = 1; e_busy = 0; e_fc = 0;
    end else begin
      act  = (ms != 0);
      last = (mh == SHT - 1) && (mv == SVT - 1);
      e_hc = mh;
      e_vc = mv;
      e_de = (act && mh < SHA && mv < SVA) ? 1 : 0;
      e_hs = (act && mh >= SHA + SHFP && mh < SHA + SHFP + SHS) ? 1 : 0;
      e_vs = (act && mv >= SVA + SVFP && mv < SVA + SVFP + SVS) ? 0 : 1;
      e_ls = (act && mh == 0) ? 1 : 0;
      e_fs = (act && mh == 0 && mv == 0) ? 1 : 0;
      if (act && last) mfc = (mfc + 1) & 32'hffff;
      case (ms)
        0: if (rn) ms = 1;
        1: if (!rn) ms = last ? 0 : 2;
        default: begin
          if (rn) ms = 1;
          else if (last) ms = 0;
        end
      endcase
      if (act) begin
        if (mh == SHT - 1) begin
          mh = 0;
          mv = (mv == SVT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      e_busy = (ms != 0) ? 1 : 0;
      e_fc   = mfc;
    end
  endtask

  task automatic step_s(input bit rst, input bit rn);
    @(negedge clk_in);
    if (mdl_valid) begin
      chk("s_h_count",     32'(s_hc),   32'(e_hc));
      chk("s_v_count",     32'(s_vc),   32'(e_vc));
      chk("s_display_en",  32'(s_de),   32'(e_de));
      chk("s_h_sync",      32'(s_hs),   32'(e_hs));
      chk("s_v_sync",      32'(s_vs),   32'(e_vs));
      chk("s_line_start",  32'(s_ls),   32'(e_ls));
      chk("s_frame_start", 32'(s_fs),   32'(e_fs));
      chk("s_busy",        32'(s_busy), 32'(e_busy));
      chk("s_frame_count", 32'(s_fc),   32'(e_fc));
    end
    s_reset = rst;
    s_run   = rn;
    model_step(rst, rn);
    mdl_valid = 1'b1;
  endtask

  int cycles;
  int ls_t[$];
  int de_cnt[3];
  int hs_low, hs_first, vs_low, fs_n;

  initial begin
    d_reset = 1'b1; d_run = 1'b0;
    s_reset = 1'b1; s_run = 1'b0;
    repeat (2) @(negedge clk_in);

    // Reset state of the default instance
    chk("d_rst_h_sync",      32'(d_hs),   32'd1);
    chk("d_rst_v_sync",      32'(d_vs),   32'd1);
    chk("d_rst_display_en",  32'(d_de),   32'd0);
    chk("d_rst_busy",        32'(d_busy), 32'd0);
    chk("d_rst_frame_count", 32'(d_fc),   32'd0);
    chk("d_rst_h_count",     32'(d_hc),   32'd0);
    chk("d_rst_frame_start", 32'(d_fs),   32'd0);

    // First frame_start two cycles after run rises
    d_reset = 1'b0;
    d_run   = 1'b1;
    cycles  = 0;
    do begin
      @(negedge clk_in);
      cycles++;
    end while (!d_fs && cycles < 10);
    chk("d_first_fs_latency", 32'(cycles), 32'd2);
    chk("d_first_h_count",    32'(d_hc),   32'd0);
    chk("d_first_v_count",    32'(d_vc),   32'd0);
    chk("d_first_line_start", 32'(d_ls),   32'd1);
    chk("d_first_display_en", 32'(d_de),   32'd1);
    chk("d_first_busy",       32'(d_busy), 32'd1);

    // Three full lines of default timing
    hs_low = 0; hs_first = -1; vs_low = 0; fs_n = 0;
    for (int i = 0; i < 3; i++) de_cnt[i] = 0;
    for (int k = 0; k < 2400; k++) begin
      if (d_ls) ls_t.push_back(k);
      if (d_de && d_vc < 3) de_cnt[int'(d_vc)]++;
      if (!d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_hc);
      end
      if (!d_vs) vs_low++;
      if (d_fs) fs_n++;
      @(negedge clk_in);
    end
    chk("d_line_start_count", 32'(ls_t.size()), 32'd3);
    if (ls_t.size() == 3) begin
      chk("d_line_period_0", 32'(ls_t[1] - ls_t[0]), 32'd800);
      chk("d_line_period_1", 32'(ls_t[2] - ls_t[1]), 32'd800);
    end
    chk("d_de_line0",        32'(de_cnt[0]), 32'd640);
    chk("d_de_line1",        32'(de_cnt[1]), 32'd640);
    chk("d_de_line2",        32'(de_cnt[2]), 32'd640);
    chk("d_hsync_low_3lines", 32'(hs_low),   32'd288);
    chk("d_hsync_first_col", 32'(hs_first),  32'd656);
    chk("d_vsync_low_top",   32'(vs_low),    32'd0);
    chk("d_frame_starts",    32'(fs_n),      32'd1);
    chk("d_pos_after_3",     32'(d_vc),      32'd3);
    chk("d_col_after_3",     32'(d_hc),      32'd0);

    // Small instance: reset, idle, three frames and more
    repeat (2) step_s(1'b1, 1'b0);
    repeat (3) step_s(1'b0, 1'b0);
    repeat (144) step_s(1'b0, 1'b1);
    for (int g = 0; g < 100 && !(mv == 2 && mh == 0); g++) step_s(1'b0, 1'b1);

    // Drop run mid-frame: frame completes, then idle
    repeat (60) step_s(1'b0, 1'b0);
    step_s(1'b0, 1'b0);
    chk("s_drain_frame_count", 32'(s_fc),   32'd4);
    chk("s_drain_busy",        32'(s_busy), 32'd0);
    chk("s_drain_h_count",     32'(s_hc),   32'd0);

    // Drop and re-raise run during drain
    repeat (20) step_s(1'b0, 1'b1);
    repeat (5)  step_s(1'b0, 1'b0);
    repeat (10) step_s(1'b0, 1'b1);
    repeat (60) step_s(1'b0, 1'b0);
    step_s(1'b0, 1'b0);
    chk("s_redrain_frame_count", 32'(s_fc), 32'd5);

    // Reset mid-frame aborts without a frame_count increment
    repeat (30) step_s(1'b0, 1'b1);
    step_s(1'b1, 1'b1);
    step_s(1'b0, 1'b0);
    chk("s_rst_frame_count", 32'(s_fc),   32'd0);
    chk("s_rst_busy",        32'(s_busy), 32'd0);
    chk("s_rst_h_sync",      32'(s_hs),   32'd0);
    chk("s_rst_v_sync",      32'(s_vs),   32'd1);
    chk("s_rst_h_count",     32'(s_hc),   32'd0);
    repeat (5) step_s(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
